// File: rtl/eka_mem_arbiter.sv
// eka_mem_arbiter
//   Single-port memory sequencer for the Eka single-cycle core. One memory
//   port is shared between instruction fetch and core load/store. A fetched
//   instruction is held in `instruction` while the core's data access
//   completes. The block also counts retired instructions.
//
//   Optional feature macro: EKA_MEM_ARB_BYPASS_EN
//     defined   : a completing data access in EXEC retires in the same cycle
//                 and returns mem_rdata combinationally (DONE is skipped).
//     undefined : a data access always retires from DONE with registered data.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous reset, active low
//   inst_addr     in   core PC byte address
//   data_addr     in   core data byte address (low ADDR_WIDTH bits used)
//   core_wr_data  in   core store data
//   core_mem_wr   in   core store request
//   core_mem_rd   in   core load request
//   instruction   out  held instruction
//   inst_valid    out  instruction is valid for execution
//   mem_rd_data   out  load data to the core
//   data_stall    out  core must not advance PC / write register file
//   mem_req       out  memory request
//   mem_we        out  1 = write, 0 = read
//   mem_addr      out  memory byte address
//   mem_wdata     out  memory write data
//   mem_ready     in   transfer completes when mem_req && mem_ready
//   mem_rdata     in   memory read data, valid in the completing cycle
//   retired_count out  retired instruction count (wraps)
module eka_mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           core_wr_data,
    input  logic                  core_mem_wr,
    input  logic                  core_mem_rd,
    output logic [31:0]           instruction,
    output logic                  inst_valid,
    output logic [31:0]           mem_rd_data,
    output logic                  data_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           retired_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] rdata_q;
    logic        data_access;

    // The core decodes rd/wr from the held instruction, so these inputs are
    // stable for the whole EXEC phase and can drive the request directly.
    assign data_access = (state == EXEC) && (core_mem_rd || core_mem_wr);

    // Outputs are decoded from state (plus the core's decode in EXEC). Since
    // the state register resets asynchronously, mem_req drops the moment
    // reset asserts, abandoning any outstanding transfer.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = inst_addr;
        mem_wdata   = 32'd0;
        inst_valid  = 1'b0;
        data_stall  = 1'b1;
        mem_rd_data = rdata_q;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (data_access) begin
                    mem_req   = 1'b1;
                    mem_addr  = data_addr[ADDR_WIDTH-1:0];
                    // A combined load+store is issued as a write; read data
                    // is still captured on completion.
                    mem_we    = core_mem_wr;
                    mem_wdata = core_wr_data;
`ifdef EKA_MEM_ARB_BYPASS_EN
                    if (mem_ready) begin
                        data_stall  = 1'b0;
                        mem_rd_data = mem_rdata;
                    end
`endif
                end else begin
                    data_stall = 1'b0;
                end
            end
            DONE: begin
                inst_valid = 1'b1;
                data_stall = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            instruction   <= 32'd0;
            rdata_q       <= 32'd0;
            retired_count <= 32'd0;
        end else begin
            if (inst_valid && !data_stall) begin
                retired_count <= retired_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (mem_ready) begin
                        instruction <= mem_rdata;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (!data_access) begin
                        state <= FETCH;
                    end else if (mem_ready) begin
                        rdata_q <= mem_rdata;
`ifdef EKA_MEM_ARB_BYPASS_EN
                        state   <= FETCH;
`else
                        state   <= DONE;
`endif
                    end
                end
                // Core rd/wr are ignored here so an access is never reissued.
                DONE: begin
                    state <= FETCH;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eka_mem_arbiter.sv
// Testbench for eka_mem_arbiter: directed stimulus, a transaction-level
// reference model checked every cycle, and literal expectations that pin
// the model at key points.
module tb_eka_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] data_addr;
    logic [31:0] core_wr_data;
    logic        core_mem_wr;
    logic        core_mem_rd;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] mem_rd_data;
    logic        data_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;
    int n_store = 0;

    eka_mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .inst_addr(inst_addr),
        .data_addr(data_addr),
        .core_wr_data(core_wr_data),
        .core_mem_wr(core_mem_wr),
        .core_mem_rd(core_mem_rd),
        .instruction(instruction),
        .inst_valid(inst_valid),
        .mem_rd_data(mem_rd_data),
        .data_stall(data_stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: tracks whether an instruction is held, whether its
    // data access has already been served, and the architectural registers.
    logic        m_started, m_have, m_served;
    logic [31:0] m_instr, m_rdq, m_cnt;
    logic        e_access, e_req, e_stall, e_retire;
    logic [31:0] e_rd;

    always_comb begin
        e_access = m_have && !m_served && (core_mem_rd || core_mem_wr);
        e_req    = m_started && (!m_have || e_access);
        e_stall  = !m_have || e_access;
        e_rd     = m_rdq;
`ifdef EKA_MEM_ARB_BYPASS_EN
        if (e_access && mem_ready) begin
            e_stall = 1'b0;
            e_rd    = mem_rdata;
        end
`endif
        e_retire = m_have && !e_stall;
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_started <= 1'b0;
            m_have    <= 1'b0;
            m_served  <= 1'b0;
            m_instr   <= 32'd0;
            m_rdq     <= 32'd0;
            m_cnt     <= 32'd0;
        end else begin
            if (e_retire) m_cnt <= m_cnt + 32'd1;
            if (!m_started) begin
                m_started <= 1'b1;
            end else if (!m_have) begin
                if (mem_ready) begin
                    m_have  <= 1'b1;
                    m_instr <= mem_rdata;
                end
            end else if (e_access) begin
                if (mem_ready) begin
                    m_rdq <= mem_rdata;
`ifdef EKA_MEM_ARB_BYPASS_EN
                    m_have <= 1'b0;
`else
                    m_served <= 1'b1;
`endif
                end
            end else begin
                m_have   <= 1'b0;
                m_served <= 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("m_req", 32'(mem_req), 32'(e_req));
        chk("m_valid", 32'(inst_valid), 32'(m_have));
        chk("m_stall", 32'(data_stall), 32'(e_stall));
        chk("m_count", retired_count, m_cnt);
        chk("m_instr", instruction, m_instr);
        chk("m_rd_data", mem_rd_data, e_rd);
        if (e_req) begin
            chk("m_addr", mem_addr, m_have ? data_addr : inst_addr);
            chk("m_we", 32'(mem_we), 32'(e_access && core_mem_wr));
            if (e_access && core_mem_wr) chk("m_wdata", mem_wdata, core_wr_data);
        end
    end

    // Completed write transfers.
    always @(posedge clk) begin
        if (reset && mem_req && mem_ready && mem_we) n_store++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        inst_addr    = 32'h0;
        data_addr    = 32'h0;
        core_wr_data = 32'h0;
        core_mem_wr  = 1'b0;
        core_mem_rd  = 1'b0;
        mem_ready    = 1'b1;
        mem_rdata    = 32'h00500093;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // IDLE cycle after release
        at_neg();
        chk("idle_req", 32'(mem_req), 32'h0);
        chk("idle_stall", 32'(data_stall), 32'h1);
        chk("rst_count", retired_count, 32'h0);
        chk("rst_instr", instruction, 32'h0);

        // First fetch at address 0
        step();
        at_neg();
        chk("first_fetch_req", 32'(mem_req), 32'h1);
        chk("first_fetch_addr", mem_addr, 32'h0);
        chk("first_fetch_we", 32'(mem_we), 32'h0);

        // EXEC of addi: retires in one cycle
        step();
        at_neg();
        chk("alu_valid", 32'(inst_valid), 32'h1);
        chk("alu_stall", 32'(data_stall), 32'h0);
        chk("alu_instr", instruction, 32'h00500093);
        chk("alu_req", 32'(mem_req), 32'h0);

        // Fetch of the load at 0x10
        step();
        inst_addr = 32'h10;
        mem_rdata = 32'h00002083;
        at_neg();
        chk("alu_retired", retired_count, 32'h1);
        chk("fetch2_addr", mem_addr, 32'h10);

        // Load with two wait states
        step();
        core_mem_rd = 1'b1;
        data_addr   = 32'h100;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        at_neg();
        chk("ld_addr_w1", mem_addr, 32'h100);
        chk("ld_stall_w1", 32'(data_stall), 32'h1);
        step();
        at_neg();
        chk("ld_addr_w2", mem_addr, 32'h100);
        step();
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        at_neg();
        chk("ld_addr_w3", mem_addr, 32'h100);
`ifdef EKA_MEM_ARB_BYPASS_EN
        chk("ld_byp_rd", mem_rd_data, 32'hDEADBEEF);
        chk("ld_byp_stall", 32'(data_stall), 32'h0);
`else
        chk("ld_w3_stall", 32'(data_stall), 32'h1);
        step();
        mem_rdata = 32'h00102223;
        at_neg();
        chk("ld_done_rd", mem_rd_data, 32'hDEADBEEF);
        chk("ld_done_stall", 32'(data_stall), 32'h0);
        chk("ld_done_req", 32'(mem_req), 32'h0);
`endif

        // Fetch of the store at 0x14
        step();
        core_mem_rd = 1'b0;
        inst_addr   = 32'h14;
        mem_rdata   = 32'h00102223;
        at_neg();
        chk("st_fetch_addr", mem_addr, 32'h14);
        chk("ld_retired", retired_count, 32'h2);

        // Store, zero wait
        step();
        core_mem_wr  = 1'b1;
        core_wr_data = 32'hCAFEF00D;
        data_addr    = 32'h204;
        at_neg();
        chk("st_req", 32'(mem_req), 32'h1);
        chk("st_we", 32'(mem_we), 32'h1);
        chk("st_wdata", mem_wdata, 32'hCAFEF00D);
        chk("st_addr", mem_addr, 32'h204);
`ifndef EKA_MEM_ARB_BYPASS_EN
        step();
        at_neg();
        chk("st_done_req", 32'(mem_req), 32'h0);
`endif

        // Fetch at 0x18, then a load that is cut off by reset
        step();
        core_mem_wr = 1'b0;
        inst_addr   = 32'h18;
        mem_rdata   = 32'h0000a103;
        at_neg();
        chk("st_once", 32'(n_store), 32'h1);
        chk("st_retired", retired_count, 32'h3);
        step();
        core_mem_rd = 1'b1;
        data_addr   = 32'h300;
        mem_ready   = 1'b0;
        at_neg();
        chk("wait_req", 32'(mem_req), 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_req_drop", 32'(mem_req), 32'h0);
        chk("rst_count_clr", retired_count, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_stall", 32'(data_stall), 32'h1);

        // Restart; run ALU instructions under the model
        @(posedge clk);
        #1;
        reset       = 1'b1;
        core_mem_rd = 1'b0;
        inst_addr   = 32'h20;
        mem_ready   = 1'b1;
        mem_rdata   = 32'h00500093;
        repeat (8) step();

        // Combined load+store: issued as a write, read data still captured
        core_mem_rd  = 1'b1;
        core_mem_wr  = 1'b1;
        core_wr_data = 32'h5A5A0000;
        data_addr    = 32'h40;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 32'h1000 + 32'(i);
            step();
        end
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
